// File: rtl/nec_prefetch.sv
// nec_prefetch: instruction prefetch queue for the NEC core.
// Fetches opcode bytes from the BIU into an 8-byte address-indexed queue,
// derives consumption from the decoder pc and follows set_pc redirects.
// Optional feature macro: NEC_PREFETCH_WORD_EN (16-bit word fetches when aligned).
module nec_prefetch (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce_1,
    input  logic             ce_2,
    input  logic [15:0]      pc,
    input  logic             set_pc,
    input  logic [15:0]      new_pc,
    input  logic [15:0]      cs,
    input  logic             block_prefetch,
    output logic [7:0][7:0]  ipq,
    output logic [3:0]       ipq_len,
    output logic             bus_req,
    output logic [19:0]      bus_addr,
    output logic             bus_word,
    input  logic             bus_ack,
    input  logic [15:0]      bus_rdata
);

    localparam int unsigned QLEN_W = 4;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned PC_W   = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic                   primed_q, primed_d;
    logic [7:0][7:0]        ipq_q, ipq_d;
    logic                   bus_req_q, bus_req_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic                   bus_word_q, bus_word_d;

    logic                   ce_c;
    logic [QLEN_W-1:0]      len_c;
    logic [QLEN_W-1:0]      free_c;
    logic                   word_ok_c;
    logic                   byte_ok_c;
    logic [2:0]             widx_c;

    // Queue occupancy and fetch-size qualification.
    always_comb begin
        ce_c   = ce_1 | ce_2;
        len_c  = primed_q ? QLEN_W'(fetch_pc_q - pc) : '0;
        free_c = QLEN_W'(8) - len_c;
`ifdef NEC_PREFETCH_WORD_EN
        word_ok_c = ~fetch_pc_q[0] && (free_c >= QLEN_W'(2));
`else
        word_ok_c = 1'b0;
`endif
        byte_ok_c = free_c >= QLEN_W'(1);
        widx_c    = fetch_pc_q[2:0];
    end

    // Next-state: request issue, ack handling, redirect/discard.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        primed_d   = primed_q;
        ipq_d      = ipq_q;
        bus_req_d  = bus_req_q;
        bus_addr_d = bus_addr_q;
        bus_word_d = bus_word_q;

        if (ce_c) begin
            case (state_q)
                S_IDLE: begin
                    if (primed_q && !block_prefetch && !set_pc && (word_ok_c || byte_ok_c)) begin
                        bus_req_d  = 1'b1;
                        bus_addr_d = {cs, 4'b0000} + {4'b0000, fetch_pc_q};
                        bus_word_d = word_ok_c;
                        state_d    = S_REQ;
                    end
                end
                S_REQ: begin
                    if (set_pc) begin
                        // In-flight data belongs to the old stream.
                        if (bus_ack) begin
                            bus_req_d = 1'b0;
                            state_d   = S_IDLE;
                        end else begin
                            state_d   = S_DISCARD;
                        end
                    end else if (bus_ack) begin
                        if (bus_word_q) begin
                            ipq_d[{widx_c[2:1], 1'b0}] = bus_rdata[7:0];
                            ipq_d[{widx_c[2:1], 1'b1}] = bus_rdata[15:8];
                        end else begin
                            ipq_d[widx_c] = widx_c[0] ? bus_rdata[15:8] : bus_rdata[7:0];
                        end
                        fetch_pc_d = fetch_pc_q + PC_W'(bus_word_q ? 2 : 1);
                        bus_req_d  = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (bus_ack) begin
                        bus_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
                default: begin
                    bus_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            endcase

            if (set_pc) begin
                fetch_pc_d = new_pc;
                primed_d   = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= '0;
            primed_q   <= 1'b0;
            ipq_q      <= '0;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
            bus_word_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            primed_q   <= primed_d;
            ipq_q      <= ipq_d;
            bus_req_q  <= bus_req_d;
            bus_addr_q <= bus_addr_d;
            bus_word_q <= bus_word_d;
        end
    end

    // Outputs; ipq_len follows pc combinationally.
    assign ipq      = ipq_q;
    assign ipq_len  = len_c;
    assign bus_req  = bus_req_q;
    assign bus_addr = bus_addr_q;
    assign bus_word = bus_word_q;

endmodule

// File: tb/tb_nec_prefetch.sv
// Directed testbench for nec_prefetch; expectations adapt to NEC_PREFETCH_WORD_EN.
module tb_nec_prefetch;

`ifdef NEC_PREFETCH_WORD_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ce_1, ce_2;
    logic [15:0]     pc, new_pc, cs;
    logic            set_pc, block_prefetch;
    logic [7:0][7:0] ipq;
    logic [3:0]      ipq_len;
    logic            bus_req, bus_word, bus_ack;
    logic [19:0]     bus_addr;
    logic [15:0]     bus_rdata;

    int test_cnt = 0;
    int fail_cnt = 0;

    logic [19:0]     old_addr;
    logic [7:0][7:0] snap;
    int              acks;

    always #5 clk = ~clk;

    // Byte pattern at a physical address: low address byte xor 0x5A.
    function automatic logic [7:0] bval(input logic [19:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    assign bus_rdata = {bval(bus_addr | 20'h1), bval(bus_addr & ~20'h1)};

    nec_prefetch u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ce_1           (ce_1),
        .ce_2           (ce_2),
        .pc             (pc),
        .set_pc         (set_pc),
        .new_pc         (new_pc),
        .cs             (cs),
        .block_prefetch (block_prefetch),
        .ipq            (ipq),
        .ipq_len        (ipq_len),
        .bus_req        (bus_req),
        .bus_addr       (bus_addr),
        .bus_word       (bus_word),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int max);
        for (int i = 0; i < max && !bus_req; i++) tick();
        check_eq("wait_req", 64'(bus_req), 64'(1));
    endtask

    task automatic ack_once();
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
    endtask

    task automatic redirect(input logic [15:0] target, input logic [15:0] seg);
        set_pc = 1'b1;
        new_pc = target;
        pc     = target;
        cs     = seg;
        tick();
        set_pc = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; ce_1 = 1'b1; ce_2 = 1'b0;
        pc = '0; new_pc = '0; cs = '0;
        set_pc = 1'b0; block_prefetch = 1'b0; bus_ack = 1'b0;
        #12;
        check_eq("rst_req",  64'(bus_req),  64'(0));
        check_eq("rst_addr", 64'(bus_addr), 64'(0));
        check_eq("rst_word", 64'(bus_word), 64'(0));
        check_eq("rst_len",  64'(ipq_len),  64'(0));
        check_eq("rst_ipq",  64'(ipq),      64'(0));
        reset_n = 1'b1;
        tick(); tick(); tick();
        check_eq("unprimed_req", 64'(bus_req), 64'(0));

        // Prime and fill from 0xF000:0x0100.
        redirect(16'h0100, 16'hF000);
        check_eq("prime_len", 64'(ipq_len), 64'(0));
        check_eq("prime_noreq", 64'(bus_req), 64'(0));
        tick();
        check_eq("first_req",  64'(bus_req),  64'(1));
        check_eq("first_addr", 64'(bus_addr), 64'(20'hF0100));
        check_eq("first_word", 64'(bus_word), 64'(WEN));
        acks = 0;
        for (int k = 0; k < 12 && ipq_len < 4'd8; k++) begin
            wait_req(4);
            ack_once();
            acks++;
        end
        check_eq("fill_len",  64'(ipq_len), 64'(8));
        check_eq("fill_acks", 64'(acks),    64'(WEN ? 4 : 8));
        tick(); tick(); tick();
        check_eq("full_noreq", 64'(bus_req), 64'(0));
        check_eq("fill_ipq", 64'(ipq), 64'h5D5C5F5E_59585B5A);
        pc = 16'h0103;
        #1;
        check_eq("consume_len", 64'(ipq_len), 64'(5));

        // Odd redirect realigns with a byte fetch from the high lane.
        redirect(16'h0101, 16'hF000);
        check_eq("odd_len0", 64'(ipq_len), 64'(0));
        tick();
        check_eq("odd_req",  64'(bus_req),  64'(1));
        check_eq("odd_addr", 64'(bus_addr), 64'(20'hF0101));
        check_eq("odd_word", 64'(bus_word), 64'(0));
        ack_once();
        check_eq("odd_len1", 64'(ipq_len), 64'(1));
        check_eq("odd_byte", 64'(ipq[1]),  64'(8'h5B));
        check_eq("gap_idle", 64'(bus_req), 64'(0));
        tick();
        check_eq("align_addr", 64'(bus_addr), 64'(20'hF0102));
        check_eq("align_word", 64'(bus_word), 64'(WEN));
        ack_once();
        check_eq("align_len", 64'(ipq_len), 64'(WEN ? 3 : 2));

        // Flush while a request is outstanding; ack arrives 3 cycles later.
        wait_req(4);
        old_addr = bus_addr;
        snap     = ipq;
        redirect(16'h0200, 16'hF000);
        check_eq("disc_req",  64'(bus_req),  64'(1));
        check_eq("disc_addr", 64'(bus_addr), 64'(old_addr));
        check_eq("disc_len",  64'(ipq_len),  64'(0));
        tick(); tick();
        ack_once();
        check_eq("disc_drop_req", 64'(bus_req), 64'(0));
        check_eq("disc_drop_len", 64'(ipq_len), 64'(0));
        check_eq("disc_drop_ipq", 64'(ipq),     64'(snap));
        tick();
        check_eq("disc_next", 64'(bus_addr), 64'(20'hF0200));

        // Ack coincident with redirect.
        bus_ack = 1'b1;
        redirect(16'h0300, 16'hF000);
        bus_ack = 1'b0;
        check_eq("coin_req", 64'(bus_req), 64'(0));
        check_eq("coin_len", 64'(ipq_len), 64'(0));
        check_eq("coin_ipq", 64'(ipq),     64'(snap));
        tick();
        check_eq("coin_req2", 64'(bus_req),  64'(1));
        check_eq("coin_addr", 64'(bus_addr), 64'(20'hF0300));
        ack_once();
        check_eq("coin_len2", 64'(ipq_len), 64'(WEN ? 2 : 1));

        // Wrap of fetch_pc and pc across 0xFFFF.
        redirect(16'hFFFE, 16'h0000);
        tick();
        check_eq("wrap_addr", 64'(bus_addr), 64'(20'h0FFFE));
        check_eq("wrap_word", 64'(bus_word), 64'(WEN));
        ack_once();
        for (int k = 0; k < 4 && ipq_len < 4'd2; k++) begin
            wait_req(4);
            ack_once();
        end
        check_eq("wrap_len",  64'(ipq_len), 64'(2));
        check_eq("wrap_byte", 64'(ipq[6]),  64'(8'hA4));
        check_eq("wrap_hi",   64'(ipq[7]),  64'(8'hA5));
        wait_req(4);
        check_eq("wrap_next", 64'(bus_addr), 64'(20'h00000));
        ack_once();
        check_eq("wrap_len2", 64'(ipq_len), 64'(WEN ? 4 : 3));
        pc = 16'hFFFF;
        #1;
        check_eq("wrap_pc_ffff", 64'(ipq_len), 64'(WEN ? 3 : 2));
        pc = 16'h0000;
        #1;
        check_eq("wrap_pc_0000", 64'(ipq_len), 64'(WEN ? 2 : 1));

        // block_prefetch at ipq_len 6, then clock-enable gating.
        redirect(16'h0400, 16'hF000);
        for (int k = 0; k < 10 && ipq_len < 4'd6; k++) begin
            wait_req(4);
            ack_once();
        end
        check_eq("blk_len", 64'(ipq_len), 64'(6));
        block_prefetch = 1'b1;
        tick(); tick(); tick();
        check_eq("blk_noreq", 64'(bus_req), 64'(0));
        block_prefetch = 1'b0;
        ce_1 = 1'b0;
        tick();
        check_eq("ce_off_noreq", 64'(bus_req), 64'(0));
        ce_2 = 1'b1;
        tick();
        check_eq("rel_req",  64'(bus_req),  64'(1));
        check_eq("rel_addr", 64'(bus_addr), 64'(20'hF0406));
        check_eq("rel_word", 64'(bus_word), 64'(WEN));
        ce_2 = 1'b0;
        bus_ack = 1'b1;
        tick();
        check_eq("ce_off_ack_req", 64'(bus_req), 64'(1));
        check_eq("ce_off_ack_len", 64'(ipq_len), 64'(6));
        ce_1 = 1'b1;
        tick();
        bus_ack = 1'b0;
        check_eq("ce_on_ack_req", 64'(bus_req), 64'(0));
        check_eq("ce_on_ack_len", 64'(ipq_len), 64'(WEN ? 8 : 7));
        check_eq("ce_on_ack_byte", 64'(ipq[6]), 64'(8'h5C));

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
